// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder shared by every bit of the serial addition.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder reused LSB-first over WIDTH cycles,
// sequenced by a three-state IDLE/RUN/DONE controller.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;

    fa_bit u_fa (
        .x  (op_a[cnt]),
        .y  (op_b[cnt]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[cnt] <= fa_s;
                    carry    <= fa_co;
                    // cout only moves when the result completes, so it keeps the
                    // previous answer visible while the next one is assembled.
                    if (cnt == LAST) begin
                        cout  <= fa_co;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of the 8-bit serial adder controller.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_vec;
    int n_miss;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One addition; operands are scrambled every RUN cycle, and when poke>=0
    // a stray start with a=0x11 is raised on that busy cycle.
    task automatic op(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input int poke, input string tag);
        logic [8:0] ref9;
        int nb;
        int g;
        ref9 = {1'b0, x} + {1'b0, y} + {8'b0, c};
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        g = 0;
        while (!done && g < 40) begin
            if (busy) nb++;
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            if (nb == poke) begin
                a = 8'h11;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            g++;
        end
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy cycles"}, 32'(nb), 32'd8);
        check({tag, " sum"}, 32'(sum), 32'(ref9[7:0]));
        check({tag, " cout"}, 32'(cout), 32'(ref9[8]));
        @(negedge clk);
        check({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [7:0] rx;
        logic [7:0] ry;
        logic       rc;
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        cin    = 1'b0;

        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op(8'h5A, 8'h3C, 1'b0, -1, "5a+3c");
        op(8'hFF, 8'h01, 1'b0, -1, "ff+01");
        op(8'hFF, 8'hFF, 1'b1, -1, "ff+ff+1");
        op(8'h01, 8'h02, 1'b0, 3, "start during run");

        // Back-to-back: new start held in the DONE cycle.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first sum", 32'(sum), 32'h30);
        check("b2b first cout", 32'(cout), 32'd0);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b gap", 32'(n), 32'd9);
        check("b2b second sum", 32'(sum), 32'h00);
        check("b2b second cout", 32'(cout), 32'd1);
        @(negedge clk);
        check("b2b done width", 32'(done), 32'd0);

        // Asynchronous abort on busy cycle 4.
        a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort pre busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort no done", 32'(pulses), 32'd0);
        op(8'h07, 8'h09, 1'b0, -1, "07+09 after abort");

        // Randomized scoreboard against a+b+cin.
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
            op(rx, ry, rc, -1, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled only on clk rising edge.
REQ-005 a  input  WIDTH  operand A; sampled with start.
REQ-006 b  input  WIDTH  operand B; sampled with start.
REQ-007 cin  input  1  carry-in; sampled with start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse; sum/cout valid.
REQ-010 sum  output  WIDTH  result, LSB-first assembled.
REQ-011 cout  output  1  final carry-out.

Function
REQ-012 Block SHALL compute {cout,sum} = a + b + cin using one 1-bit full adder, time-multiplexed one bit per clock, LSB first.
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 SHALL latch a, b, cin into operand/carry registers, clear the bit counter, and go to RUN; start=0 SHALL stay in IDLE.
REQ-015 RUN: each edge SHALL feed operand bit[cnt] and the carry register to the full adder, write the sum bit into sum[cnt], update the carry register with the adder carry, and increment cnt.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, FSM SHALL go to DONE.
REQ-017 Latency: start sampled at edge k means done=1 in the cycle following edge k+WIDTH.
REQ-018 busy SHALL be 1 exactly when state=RUN (WIDTH cycles per operation).
REQ-019 done SHALL be 1 exactly when state=DONE, for one cycle.
REQ-020 DONE: start=1 SHALL be accepted like IDLE (back-to-back, next result after another WIDTH+1 edges); start=0 SHALL go to IDLE.
REQ-021 start during RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-022 Input changes on a, b, cin after the start sample SHALL NOT affect the result in progress.
REQ-023 sum and cout SHALL hold the last completed result from DONE until the next start is accepted; during RUN sum bits above cnt are undefined-but-stable (partial result), cout SHALL equal the carry register only in DONE/IDLE.
REQ-024 Counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within an operation.
REQ-025 Overflow SHALL be reported only through cout; sum SHALL be modulo 2^WIDTH.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, sum=0, cout=0, cnt=0, operand and carry registers 0.
REQ-027 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-028 First start is accepted on the first rising edge after rst deasserts.

Structure
REQ-029 Shared package serial_add_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-030 One sub-module, fa_bit (inputs x, y, ci; outputs s, co), SHALL implement the combinational 1-bit full adder, instantiated once; all sequencing lives in serial_add_ctrl.

Verification (WIDTH=8)
REQ-031 start with a=0x5A, b=0x3C, cin=0 -> after 8 busy cycles, done pulse, sum=0x96, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 start pulsed again with a=0x11 at busy cycle 3 of a 0x01+0x02 operation -> ignored, result sum=0x03, cout=0, single done pulse.
REQ-034 start held high with new operands in the DONE cycle (0x10+0x20 then 0x80+0x80) -> two done pulses 9 cycles apart, results 0x30/cout 0 then 0x00/cout 1.
REQ-035 rst asserted at busy cycle 4 -> outputs zero immediately, no done pulse; a subsequent start 0x07+0x09 yields sum=0x10 after normal latency.
REQ-036 Operands changed every cycle during RUN -> result matches values sampled at start; randomized 1000-operation scoreboard vs a+b+cin passes.
